// File: rtl/motor_ramp_controller_if.sv
// motor_ramp_controller_if: APB3 register bus between host and ramp controller
interface motor_ramp_controller_if;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  modport master(output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
  modport slave(input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/motor_ramp_controller.sv
// motor_ramp_controller: APB-programmed multi-channel H-bridge PWM with duty ramping, dead time and brake
module motor_ramp_controller #(
  parameter int NUM_CH   = 2,
  parameter int PERIOD   = 1000000,
  parameter int RAMP_DIV = 10000,
  parameter int DEAD     = 50000
) (
  input  logic                      PCLK,
  input  logic                      PRESERN,
  motor_ramp_controller_if.slave    bus,
  output logic [NUM_CH-1:0]         HB1,
  output logic [NUM_CH-1:0]         HB2
);
  localparam int CW   = $clog2(PERIOD);
  localparam int TW   = $clog2(PERIOD + 1);
  localparam int PW   = $clog2(RAMP_DIV + 1);
  localparam int DW   = $clog2(DEAD + 1);
  localparam int STEP = PERIOD / 100;
  typedef enum logic [1:0] {RUN, RAMPDN, DEADT, BRAKE} st_t;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     pre;
  logic              tick, wr;
  logic [5:0]        idx;
  logic [6:0]        wduty;
  logic [31:0]       rd [NUM_CH];
  logic [NUM_CH-1:0] busy;
  logic              unused_bits;
  assign idx         = bus.PADDR[7:2];
  assign wr          = bus.PSEL & bus.PENABLE & bus.PWRITE;
  assign wduty       = bus.PWDATA[6:0] > 7'd100 ? 7'd100 : bus.PWDATA[6:0];
  assign tick        = pre == PW'(RAMP_DIV - 1);
  assign bus.PREADY  = 1'b1;
  assign bus.PSLVERR = 1'b0;
  assign unused_bits = ^{bus.PADDR[31:8], bus.PADDR[1:0], bus.PWDATA[31:9]};
  always_ff @(posedge PCLK or negedge PRESERN)
    if (!PRESERN) begin
      cnt <= '0;
      pre <= '0;
    end else begin
      cnt <= cnt == CW'(PERIOD - 1) ? '0 : cnt + 1'b1;
      pre <= tick ? '0 : pre + 1'b1;
    end
  genvar g;
  for (g = 0; g < NUM_CH; g++) begin : ch
    logic [6:0]    tgt, cur;
    logic          dreq, brk, adir, hb1, hb2, wr_ch, b, d, pwm;
    logic [DW-1:0] dcnt;
    logic [TW-1:0] thr;
    st_t           st;
    // b/d see a same-cycle write so brake and reversal act on the very next cycle
    assign wr_ch   = wr && idx == 6'(g);
    assign b       = wr_ch ? bus.PWDATA[8] : brk;
    assign d       = wr_ch ? bus.PWDATA[7] : dreq;
    assign pwm     = TW'(cnt) < thr;
    assign HB1[g]  = hb1;
    assign HB2[g]  = hb2;
    assign rd[g]   = {6'b0, st, 1'b0, cur, 6'b0, adir, brk, dreq, tgt};
    assign busy[g] = st != RUN || cur != tgt;
    always_ff @(posedge PCLK or negedge PRESERN)
      if (!PRESERN) begin
        tgt  <= '0;
        dreq <= 1'b1;
        brk  <= 1'b0;
        adir <= 1'b1;
        cur  <= '0;
        st   <= RUN;
        dcnt <= '0;
        thr  <= '0;
        hb1  <= 1'b0;
        hb2  <= 1'b0;
      end else begin
        if (wr_ch) begin
          tgt  <= wduty;
          dreq <= bus.PWDATA[7];
          brk  <= bus.PWDATA[8];
        end
        // outside RUN the threshold tracks duty live so no stale pulse survives a reversal
        thr <= (cnt == '0 || st != RUN) ? TW'(cur) * TW'(STEP) : thr;
        hb1 <= b || (st != DEADT && !adir && pwm);
        hb2 <= b || (st != DEADT && adir && pwm);
        if (b && st != BRAKE) begin
          st  <= BRAKE;
          cur <= '0;
        end else
          case (st)
            RUN:
              if (d != adir) st <= RAMPDN;
              else if (tick) cur <= cur < tgt ? cur + 1'b1 : cur > tgt ? cur - 1'b1 : cur;
            RAMPDN:
              if (d == adir) st <= RUN;
              else if (cur == '0) begin
                st   <= DEADT;
                dcnt <= DW'(DEAD);
              end else if (tick) cur <= cur - 1'b1;
            DEADT:
              if (dcnt == '0) begin
                st   <= RUN;
                adir <= dreq;
              end else dcnt <= dcnt - 1'b1;
            BRAKE:
              if (!b) begin
                st   <= RUN;
                adir <= d;
              end
          endcase
      end
  end
  always_comb begin
    bus.PRDATA = idx == 6'(NUM_CH) ? 32'(busy) : '0;
    for (int i = 0; i < NUM_CH; i++) if (idx == 6'(i)) bus.PRDATA = rd[i];
  end
endmodule

// File: tb/tb_motor_ramp_controller.sv
// tb_motor_ramp_controller: directed APB stimulus with a read scoreboard and HB duty measurements
module tb_motor_ramp_controller;
  localparam int NUM_CH = 2, PERIOD = 1000, RAMP_DIV = 10, DEAD = 200;
  logic              clk = 1'b0, rst_n = 1'b0;
  logic [NUM_CH-1:0] hb1, hb2;
  int                checks = 0, errors = 0;
  int                c1, c2, c11;
  logic [31:0]       exp_q[$];
  string             nm_q[$];
  motor_ramp_controller_if bus();
  motor_ramp_controller #(.NUM_CH(NUM_CH), .PERIOD(PERIOD), .RAMP_DIV(RAMP_DIV), .DEAD(DEAD)) dut (
    .PCLK(clk), .PRESERN(rst_n), .bus(bus), .HB1(hb1), .HB2(hb2));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (bus.PSEL && bus.PENABLE && !bus.PWRITE) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: read 0x%08h with no expected value queued", bus.PRDATA);
      end else chk(nm_q.pop_front(), bus.PRDATA, exp_q.pop_front());
      chk("resp", {30'b0, bus.PSLVERR, bus.PREADY}, 32'h1);
    end
  task automatic apb_wr(input logic [5:0] i, input logic [31:0] dat);
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = {24'b0, i, 2'b0}; bus.PWDATA = dat;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask
  task automatic apb_rd(input logic [5:0] i, input logic [31:0] exp, input string nm);
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PWRITE = 1'b0; bus.PENABLE = 1'b0; bus.PADDR = {24'b0, i, 2'b0};
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask
  task automatic run(input int n);
    c1 = 0; c2 = 0; c11 = 0;
    repeat (n) begin
      @(negedge clk);
      c1  += int'(hb1[0]);
      c2  += int'(hb2[0]);
      c11 += int'(hb1[0] & hb2[0]);
    end
  endtask
  initial begin
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
    repeat (3) @(negedge clk);
    chk("reset_hb", {hb1, hb2}, 32'h0);
    rst_n = 1'b1;
    apb_rd(0, 32'h0000_0280, "rst_ch0");
    apb_rd(1, 32'h0000_0280, "rst_ch1");
    apb_rd(2, 32'h0, "rst_status");
    apb_rd(7, 32'h0, "rst_idx7");
    // forward 50%
    apb_wr(0, 32'h0000_00B2);
    apb_rd(2, 32'h1, "status_ramping");
    run(2000);
    apb_rd(0, 32'h0032_02B2, "fwd50_ch0");
    apb_rd(2, 32'h0, "fwd50_settled");
    run(1000);
    chk("fwd50_hb2_high", c2, 500);
    chk("fwd50_hb1_high", c1, 0);
    // clamp to 100%
    apb_wr(0, 32'h0000_00FF);
    run(2000);
    apb_rd(0, 32'h0064_02E4, "clamp_ch0");
    run(1000);
    chk("full_hb2_high", c2, 1000);
    chk("full_hb1_high", c1, 0);
    // reversal from forward 50%
    apb_wr(0, 32'h0000_00B2);
    run(2000);
    apb_wr(0, 32'h0000_0032);
    run(600);
    apb_rd(0, 32'h0200_0232, "rev_deadt");
    run(80);
    chk("dead_both_low", c1 + c2, 0);
    run(1500);
    chk("rev_hb2_zero", c2, 0);
    apb_rd(0, 32'h0032_0032, "rev_done");
    run(1000);
    run(1000);
    chk("rev_hb1_high", c1, 500);
    chk("rev_hb2_high", c2, 0);
    // brake in the middle of a reversal
    apb_wr(0, 32'h0000_00B2);
    run(200);
    apb_wr(0, 32'h0000_01B2);
    @(negedge clk);
    chk("brake_next_hb", {hb1[0], hb2[0]}, 32'h3);
    apb_rd(0, 32'h0300_01B2, "brake_ch0");
    run(100);
    chk("brake_hb11", c11, 100);
    apb_wr(0, 32'h0000_00B2);
    run(2000);
    chk("unbrake_no_overlap", c11, 0);
    apb_rd(0, 32'h0032_02B2, "unbrake_ch0");
    // asynchronous reset mid-ramp
    apb_wr(1, 32'h0000_00E4);
    run(2500);
    apb_wr(0, 32'h0000_00E4);
    run(200);
    @(negedge clk);
    chk("pre_rst_hb2_1", hb2[1], 32'h1);
    #1 rst_n = 1'b0;
    #1 chk("async_rst_hb", {hb1, hb2}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    apb_rd(0, 32'h0000_0280, "post_rst_ch0");
    apb_rd(1, 32'h0000_0280, "post_rst_ch1");
    apb_rd(2, 32'h0, "post_rst_status");
    // status bit during ramp, unmapped index ignored
    apb_wr(0, 32'h0000_00B2);
    apb_rd(2, 32'h1, "status_ramp2");
    apb_wr(7, 32'h0000_01FF);
    apb_rd(7, 32'h0, "idx7_read");
    run(2000);
    apb_rd(0, 32'h0032_02B2, "final_ch0");
    apb_rd(1, 32'h0000_0280, "final_ch1");
    apb_rd(2, 32'h0, "final_status");
    @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/motor_ramp_controller.md
MOTOR_RAMP_CONTROLLER -- requirements
Module: motor_ramp_controller

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of H-bridge channels (1..8).
REQ-002 SHALL have parameter PERIOD, default 1000000, PWM period in PCLK cycles; must be a multiple of 100.
REQ-003 SHALL have parameter RAMP_DIV, default 10000, PCLK cycles per 1% duty ramp step.
REQ-004 SHALL have parameter DEAD, default 50000, PCLK cycles of dead time on direction reversal.
REQ-005 SHALL have port PCLK  input  1  sole clock.
REQ-006 SHALL have port PRESERN  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have ports PSEL, PENABLE, PWRITE  input  1 each  APB3 control.
REQ-008 SHALL have ports PADDR  input  32 and PWDATA  input  32  APB3 address/write data.
REQ-009 SHALL have ports PRDATA  output  32, PREADY  output  1 (tied 1), PSLVERR  output  1 (tied 0).
REQ-010 SHALL have ports HB1, HB2  output  NUM_CH each  per-channel bridge drives, registered.

Function
REQ-011 Register map SHALL be word index PADDR[7:2]: 0..NUM_CH-1 channel registers; NUM_CH status register; other indices read 0 and ignore writes.
REQ-012 Channel write SHALL capture target duty = PWDATA[6:0] (values >100 clamp to 100), dir_req = PWDATA[7] (1=forward), brake = PWDATA[8], in the cycle PSEL&PENABLE&PWRITE.
REQ-013 Channel read SHALL return [6:0] target, [7] dir_req, [8] brake, [9] applied dir, [22:16] current duty, [25:24] state code; status read SHALL return bit n = channel n not settled (state != RUN or current != target).
REQ-014 PRDATA SHALL be valid combinationally during the access phase; zero-wait.
REQ-015 One shared period counter SHALL count 0..PERIOD-1 and wrap to 0.
REQ-016 Each channel SHALL latch threshold = current duty * (PERIOD/100) when counter == 0; pwm = counter < threshold; duty 0 gives constant low, 100 constant high.
REQ-017 One shared ramp prescaler SHALL pulse tick every RAMP_DIV cycles; on tick each RUN channel moves current duty 1 toward target, no overshoot.
REQ-018 Per-channel FSM states: RUN(0), RAMPDN(1), DEADT(2), BRAKE(3).
REQ-019 RUN: dir_req != applied dir -> RAMPDN; brake=1 -> BRAKE.
REQ-020 RAMPDN: on tick decrement current toward 0, ignoring target; current==0 -> DEADT with dead counter loaded DEAD.
REQ-021 DEADT: outputs both 0; counter reaches 0 -> applied dir := dir_req, -> RUN (ramps up to target).
REQ-022 BRAKE: current forced 0 immediately, HB1=HB2=1; brake write of 0 -> RUN with applied dir := dir_req.
REQ-023 Brake=1 SHALL take priority over RAMPDN/DEADT from the next cycle.
REQ-024 dir_req reverting to applied dir during RAMPDN SHALL return to RUN; during DEADT SHALL complete dead time without flipping.
REQ-025 Outside BRAKE/DEADT: applied dir=1 -> HB1=0, HB2=pwm; applied dir=0 -> HB1=pwm, HB2=0; outputs one cycle after pwm.
REQ-026 HB1 and HB2 SHALL never both be 1 except in BRAKE.

Reset
REQ-027 PRESERN low SHALL asynchronously clear HB1, HB2, PRDATA-driving state, counters, current and target duty, brake, and set dir_req = applied dir = 1, state RUN.
REQ-028 Reset mid-ramp or mid-dead-time SHALL abandon the operation; first tick after release counts from prescaler 0.

Verification
REQ-029 PERIOD=1000, RAMP_DIV=10: write ch0 0x0000_00B2 (fwd, 50%) -> current rises 1 per 10 cycles to 50; HB2[0] high 500 of 1000 cycles, HB1[0]=0.
REQ-030 Write ch0 duty 127 -> readback target 100, HB2[0] constant 1 after settling.
REQ-031 At 50% fwd write dir=0 -> RAMPDN to 0, both low for DEAD cycles, then HB1[0] pulses ramping to 50%, HB2[0]=0 throughout.
REQ-032 Brake write mid-reversal -> next cycle state 3, HB1=HB2=1, current 0; brake clear -> RUN, ramp from 0.
REQ-033 Assert PRESERN low mid-ramp, no clock edge -> HB1/HB2 0 immediately; readback 0x0000_0280 after release.
REQ-034 Read index NUM_CH during ramp -> bit set; write/read index 7 -> no effect, reads 0.
